mem_arbiter: RTL and testbench

- Sequences a single-ported unified memory shared by the fetch stage (instruction reads) and the memory stage (loads/stores).
- Arbitrates between the two requesters and drives the memory address/response handshake.
- Returns read data with a one-cycle valid pulse and generates per-stage stall signals for the hazard logic.
- Data side has priority; a starvation counter guarantees fetch progress.

---
 rtl/mem_arbiter.sv | 137 +++++++++++++
 tb/tb_mem_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter for a single-ported unified memory: one transaction in
// flight, data side preferred, bounded fetch starvation, registered responses.
module mem_arbiter #(
   parameter int DATA_WIDTH   = 32,
   parameter int ADDR_WIDTH   = 32,
   parameter int STARVE_LIMIT = 4,
   localparam int BE_WIDTH    = DATA_WIDTH / 8,
   localparam int CNT_WIDTH   = $clog2(STARVE_LIMIT + 1)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  ireq_i,
   input  logic [ADDR_WIDTH-1:0] iaddr_i,
   output logic [DATA_WIDTH-1:0] irdata_o,
   output logic                  ivalid_o,
   output logic                  istall_o,
   input  logic                  dreq_i,
   input  logic                  dwe_i,
   input  logic [ADDR_WIDTH-1:0] daddr_i,
   input  logic [DATA_WIDTH-1:0] dwdata_i,
   input  logic [BE_WIDTH-1:0]   dbe_i,
   output logic [DATA_WIDTH-1:0] drdata_o,
   output logic                  dvalid_o,
   output logic                  dstall_o,
   output logic                  mem_req_o,
   output logic                  mem_we_o,
   output logic [ADDR_WIDTH-1:0] mem_addr_o,
   output logic [DATA_WIDTH-1:0] mem_wdata_o,
   output logic [BE_WIDTH-1:0]   mem_be_o,
   input  logic                  mem_gnt_i,
   input  logic                  mem_rvalid_i,
   input  logic [DATA_WIDTH-1:0] mem_rdata_i,
   output logic                  proto_err_o,
   output logic [1:0]            dbgState,
   output logic [CNT_WIDTH-1:0]  dbgStarveCnt
);

   // Handshakes: a requester holds req and its address/data stable until its
   // one-cycle valid pulse; the memory accepts an address phase on any cycle
   // where mem_req_o && mem_gnt_i, and answers with exactly one mem_rvalid_i
   // pulse in a later cycle. No back-pressure exists on the response side.

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      RESP = 2'd3
   } stateT;

   localparam logic [CNT_WIDTH-1:0] STARVE_MAX = CNT_WIDTH'(STARVE_LIMIT);

   stateT                 state;
   stateT                 stateNext;
   logic                  ownerData;
   logic [CNT_WIDTH-1:0]  starveCnt;
   logic                  anyReq;
   logic                  contested;
   logic                  pickData;

   always_comb begin
      anyReq    = ireq_i || dreq_i;
      contested = ireq_i && dreq_i;
      // Data wins unless fetch is also waiting and has lost too many times.
      pickData  = dreq_i && (!ireq_i || (starveCnt < STARVE_MAX));
   end

   always_comb begin
      stateNext = state;
      case (state)
         IDLE: if (anyReq)       stateNext = REQ;
         REQ:  if (mem_gnt_i)    stateNext = WAIT;
         WAIT: if (mem_rvalid_i) stateNext = RESP;
         RESP:                   stateNext = IDLE;
         default:                stateNext = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         ownerData   <= 1'b0;
         starveCnt   <= '0;
         mem_we_o    <= 1'b0;
         mem_addr_o  <= '0;
         mem_wdata_o <= '0;
         mem_be_o    <= '0;
         irdata_o    <= '0;
         drdata_o    <= '0;
         proto_err_o <= 1'b0;
      end else begin
         state <= stateNext;

         if (state == IDLE && anyReq) begin
            ownerData <= pickData;
            if (pickData) begin
               mem_we_o    <= dwe_i;
               mem_addr_o  <= daddr_i;
               mem_wdata_o <= dwdata_i;
               mem_be_o    <= dbe_i;
               if (contested && starveCnt != STARVE_MAX) begin
                  starveCnt <= starveCnt + 1'b1;
               end
            end else begin
               mem_we_o    <= 1'b0;
               mem_addr_o  <= iaddr_i;
               mem_wdata_o <= '0;
               mem_be_o    <= '1;
               starveCnt   <= '0;
            end
         end

         if (state == WAIT && mem_rvalid_i) begin
            if (!ownerData) begin
               irdata_o <= mem_rdata_i;
            end else if (!mem_we_o) begin
               drdata_o <= mem_rdata_i;
            end
         end

         // A response outside WAIT belongs to no live transaction.
         if (mem_rvalid_i && state != WAIT) begin
            proto_err_o <= 1'b1;
         end
      end
   end

   always_comb begin
      mem_req_o    = (state == REQ);
      ivalid_o     = (state == RESP) && !ownerData;
      dvalid_o     = (state == RESP) && ownerData;
      istall_o     = ireq_i && !ivalid_o;
      dstall_o     = dreq_i && !dvalid_o;
      dbgState     = state;
      dbgStarveCnt = starveCnt;
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: cycle-accurate checks of single fetch,
// contention, starvation, delayed grant, store and reset-while-waiting.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        ireq_i;
   logic [31:0] iaddr_i;
   logic [31:0] irdata_o;
   logic        ivalid_o;
   logic        istall_o;
   logic        dreq_i;
   logic        dwe_i;
   logic [31:0] daddr_i;
   logic [31:0] dwdata_i;
   logic [3:0]  dbe_i;
   logic [31:0] drdata_o;
   logic        dvalid_o;
   logic        dstall_o;
   logic        mem_req_o;
   logic        mem_we_o;
   logic [31:0] mem_addr_o;
   logic [31:0] mem_wdata_o;
   logic [3:0]  mem_be_o;
   logic        mem_gnt_i;
   logic        mem_rvalid_i;
   logic [31:0] mem_rdata_i;
   logic        proto_err_o;
   logic [1:0]  dbgState;
   logic [2:0]  dbgStarveCnt;

   int          total = 0;
   int          bad   = 0;
   logic [31:0] expQ[$];
   int          pulseCnt = 0;
   logic [15:0] ownerLog = '0;

   // memory model controls
   logic [31:0] memArr [0:255];
   int          gntDelay;
   int          holdCnt;
   logic        rvalidAuto;
   logic        manRvalid;
   logic [31:0] manRdata;
   logic        respPend;
   logic        respWe;
   logic [7:0]  respIdx;

   mem_arbiter dut (
      .clk         (clk),
      .rst         (rst),
      .ireq_i      (ireq_i),
      .iaddr_i     (iaddr_i),
      .irdata_o    (irdata_o),
      .ivalid_o    (ivalid_o),
      .istall_o    (istall_o),
      .dreq_i      (dreq_i),
      .dwe_i       (dwe_i),
      .daddr_i     (daddr_i),
      .dwdata_i    (dwdata_i),
      .dbe_i       (dbe_i),
      .drdata_o    (drdata_o),
      .dvalid_o    (dvalid_o),
      .dstall_o    (dstall_o),
      .mem_req_o   (mem_req_o),
      .mem_we_o    (mem_we_o),
      .mem_addr_o  (mem_addr_o),
      .mem_wdata_o (mem_wdata_o),
      .mem_be_o    (mem_be_o),
      .mem_gnt_i   (mem_gnt_i),
      .mem_rvalid_i(mem_rvalid_i),
      .mem_rdata_i (mem_rdata_i),
      .proto_err_o (proto_err_o),
      .dbgState    (dbgState),
      .dbgStarveCnt(dbgStarveCnt)
   );

   // clock / reset
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   // memory responder: grant after gntDelay REQ cycles, respond the cycle after
   assign mem_gnt_i    = mem_req_o && (holdCnt >= gntDelay);
   assign mem_rvalid_i = rvalidAuto ? respPend : manRvalid;
   assign mem_rdata_i  = !rvalidAuto ? manRdata :
                         (respWe ? 32'hBAD0BAD0 : memArr[respIdx]);

   always @(posedge clk) begin
      if (rst) begin
         respPend <= 1'b0;
         holdCnt  <= 0;
         respWe   <= 1'b0;
         respIdx  <= '0;
      end else begin
         respPend <= mem_req_o && mem_gnt_i;
         holdCnt  <= (mem_req_o && !mem_gnt_i) ? holdCnt + 1 : 0;
         if (mem_req_o && mem_gnt_i) begin
            respWe  <= mem_we_o;
            respIdx <= mem_addr_o[9:2];
         end
      end
   end

   task automatic checkVal(input string tag, input logic [31:0] got,
                           input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=0x%08h want=0x%08h", tag, got, want);
      end
   endtask

   // scoreboard: every valid pulse consumes one expected read-data value
   always @(negedge clk) begin
      if (!rst && (ivalid_o || dvalid_o)) begin
         logic [31:0] want;
         pulseCnt++;
         ownerLog = {ownerLog[14:0], dvalid_o};
         checkVal("sb_one_owner", {31'd0, ivalid_o & dvalid_o}, 32'd0);
         if (expQ.size() == 0) begin
            checkVal("sb_unexpected_pulse", 32'd1, 32'd0);
         end else begin
            want = expQ.pop_front();
            checkVal("sb_rdata", ivalid_o ? irdata_o : drdata_o, want);
         end
      end
   end

   // driver tasks
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idleInputs();
      ireq_i   = 1'b0;
      iaddr_i  = '0;
      dreq_i   = 1'b0;
      dwe_i    = 1'b0;
      daddr_i  = '0;
      dwdata_i = '0;
      dbe_i    = '0;
   endtask

   task automatic checkOutputsZero(input string tag);
      checkVal({tag, "_irdata"}, irdata_o, 32'd0);
      checkVal({tag, "_drdata"}, drdata_o, 32'd0);
      checkVal({tag, "_ivalid"}, ivalid_o, 32'd0);
      checkVal({tag, "_dvalid"}, dvalid_o, 32'd0);
      checkVal({tag, "_mem_req"}, mem_req_o, 32'd0);
      checkVal({tag, "_mem_we"}, mem_we_o, 32'd0);
      checkVal({tag, "_mem_addr"}, mem_addr_o, 32'd0);
      checkVal({tag, "_mem_wdata"}, mem_wdata_o, 32'd0);
      checkVal({tag, "_mem_be"}, mem_be_o, 32'd0);
      checkVal({tag, "_proto_err"}, proto_err_o, 32'd0);
      checkVal({tag, "_state"}, dbgState, 32'd0);
      checkVal({tag, "_starve"}, dbgStarveCnt, 32'd0);
   endtask

   initial begin
      int base;
      for (int i = 0; i < 256; i++) memArr[i] = 32'h0;
      memArr[8'h40] = 32'h00500093;   // 0x100
      memArr[8'h00] = 32'h0000CAFE;   // 0x2000
      memArr[8'h10] = 32'h12345678;   // 0x40
      idleInputs();
      rst        = 1'b1;
      gntDelay   = 0;
      rvalidAuto = 1'b1;
      manRvalid  = 1'b0;
      manRdata   = '0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutputsZero("reset");
      cyc(); rst = 1'b0;
      cyc();

      // single fetch
      cyc(); ireq_i = 1'b1; iaddr_i = 32'h100; expQ.push_back(32'h00500093);
      @(negedge clk);
      checkVal("t1_c0_istall", istall_o, 32'd1);
      checkVal("t1_c0_req", mem_req_o, 32'd0);
      cyc(); @(negedge clk);
      checkVal("t1_c1_req", mem_req_o, 32'd1);
      checkVal("t1_c1_addr", mem_addr_o, 32'h100);
      checkVal("t1_c1_we", mem_we_o, 32'd0);
      checkVal("t1_c1_be", mem_be_o, 32'hF);
      checkVal("t1_c1_istall", istall_o, 32'd1);
      cyc(); @(negedge clk);
      checkVal("t1_c2_req", mem_req_o, 32'd0);
      checkVal("t1_c2_ivalid", ivalid_o, 32'd0);
      checkVal("t1_c2_istall", istall_o, 32'd1);
      cyc(); @(negedge clk);
      checkVal("t1_c3_ivalid", ivalid_o, 32'd1);
      checkVal("t1_c3_irdata", irdata_o, 32'h00500093);
      checkVal("t1_c3_istall", istall_o, 32'd0);
      cyc(); ireq_i = 1'b0; @(negedge clk);
      checkVal("t1_c4_ivalid", ivalid_o, 32'd0);
      checkVal("t1_c4_state", dbgState, 32'd0);

      // contention: data first, then fetch
      cyc();
      ireq_i = 1'b1; iaddr_i = 32'h100;
      dreq_i = 1'b1; dwe_i = 1'b0; daddr_i = 32'h2000;
      expQ.push_back(32'h0000CAFE);
      expQ.push_back(32'h00500093);
      cyc(); @(negedge clk);
      checkVal("t2_c1_addr", mem_addr_o, 32'h2000);
      cyc(); @(negedge clk);
      checkVal("t2_c2_starve", dbgStarveCnt, 32'd1);
      cyc(); @(negedge clk);
      checkVal("t2_c3_dvalid", dvalid_o, 32'd1);
      checkVal("t2_c3_ivalid", ivalid_o, 32'd0);
      checkVal("t2_c3_istall", istall_o, 32'd1);
      cyc(); dreq_i = 1'b0; @(negedge clk);
      checkVal("t2_c4_dvalid", dvalid_o, 32'd0);
      cyc(); @(negedge clk);
      checkVal("t2_c5_req", mem_req_o, 32'd1);
      checkVal("t2_c5_addr", mem_addr_o, 32'h100);
      cyc(); @(negedge clk);
      checkVal("t2_c6_ivalid", ivalid_o, 32'd0);
      cyc(); @(negedge clk);
      checkVal("t2_c7_ivalid", ivalid_o, 32'd1);
      cyc(); ireq_i = 1'b0; @(negedge clk);
      checkVal("t2_c8_starve", dbgStarveCnt, 32'd0);

      // starvation: 4 data wins then one fetch, twice
      cyc();
      base = pulseCnt;
      ireq_i = 1'b1; iaddr_i = 32'h100;
      dreq_i = 1'b1; dwe_i = 1'b0; daddr_i = 32'h2000;
      for (int r = 0; r < 2; r++) begin
         for (int k = 0; k < 4; k++) expQ.push_back(32'h0000CAFE);
         expQ.push_back(32'h00500093);
      end
      for (int c = 0; c < 80; c++) begin
         cyc();
         if (pulseCnt >= base + 10) break;
      end
      ireq_i = 1'b0; dreq_i = 1'b0;
      checkVal("t3_pulses", pulseCnt - base, 32'd10);
      checkVal("t3_order", {22'd0, ownerLog[9:0]}, {22'd0, 10'b1111011110});
      @(negedge clk);
      checkVal("t3_starve_end", dbgStarveCnt, 32'd0);
      checkVal("t3_state_end", dbgState, 32'd0);

      // delayed grant on a load from 0x40
      cyc();
      gntDelay = 3;
      dreq_i = 1'b1; dwe_i = 1'b0; daddr_i = 32'h40;
      dwdata_i = 32'hA5A5A5A5; dbe_i = 4'b0110;
      expQ.push_back(32'h12345678);
      for (int c = 1; c <= 4; c++) begin
         cyc(); @(negedge clk);
         checkVal($sformatf("t4_c%0d_req", c), mem_req_o, 32'd1);
         checkVal($sformatf("t4_c%0d_addr", c), mem_addr_o, 32'h40);
         checkVal($sformatf("t4_c%0d_wdata", c), mem_wdata_o, 32'hA5A5A5A5);
         checkVal($sformatf("t4_c%0d_be", c), mem_be_o, 32'h6);
      end
      cyc(); @(negedge clk);
      checkVal("t4_c5_req", mem_req_o, 32'd0);
      checkVal("t4_c5_dvalid", dvalid_o, 32'd0);
      checkVal("t4_c5_dstall", dstall_o, 32'd1);
      cyc(); @(negedge clk);
      checkVal("t4_c6_dvalid", dvalid_o, 32'd1);
      checkVal("t4_c6_drdata", drdata_o, 32'h12345678);
      checkVal("t4_c6_dstall", dstall_o, 32'd0);
      cyc(); dreq_i = 1'b0; gntDelay = 0; @(negedge clk);
      checkVal("t4_c7_dvalid", dvalid_o, 32'd0);

      // store keeps previous load data
      cyc();
      dreq_i = 1'b1; dwe_i = 1'b1; daddr_i = 32'h40;
      dwdata_i = 32'hDEADBEEF; dbe_i = 4'b0011;
      expQ.push_back(32'h12345678);
      cyc(); @(negedge clk);
      checkVal("t5_c1_req", mem_req_o, 32'd1);
      checkVal("t5_c1_we", mem_we_o, 32'd1);
      checkVal("t5_c1_be", mem_be_o, 32'h3);
      checkVal("t5_c1_wdata", mem_wdata_o, 32'hDEADBEEF);
      checkVal("t5_c1_addr", mem_addr_o, 32'h40);
      cyc();
      cyc(); @(negedge clk);
      checkVal("t5_c3_dvalid", dvalid_o, 32'd1);
      checkVal("t5_c3_drdata", drdata_o, 32'h12345678);
      cyc(); dreq_i = 1'b0; dwe_i = 1'b0; @(negedge clk);
      checkVal("t5_c4_dvalid", dvalid_o, 32'd0);
      checkVal("t5_c4_we_hold", mem_we_o, 32'd1);
      checkVal("t5_c4_proto", proto_err_o, 32'd0);

      // reset while waiting, then a late response
      cyc();
      rvalidAuto = 1'b0;
      ireq_i = 1'b1; iaddr_i = 32'h100;
      cyc(); @(negedge clk);
      checkVal("t6_c1_req", mem_req_o, 32'd1);
      cyc(); @(negedge clk);
      checkVal("t6_c2_state", dbgState, 32'd2);
      cyc(); rst = 1'b1; ireq_i = 1'b0; @(negedge clk);
      checkVal("t6_c3_state", dbgState, 32'd2);
      cyc(); rst = 1'b0; @(negedge clk);
      checkOutputsZero("t6_post_rst");
      cyc(); manRvalid = 1'b1; manRdata = 32'h11112222; @(negedge clk);
      checkVal("t6_c5_proto", proto_err_o, 32'd0);
      cyc(); manRvalid = 1'b0; @(negedge clk);
      checkVal("t6_c6_proto", proto_err_o, 32'd1);
      checkVal("t6_c6_ivalid", ivalid_o, 32'd0);
      checkVal("t6_c6_irdata", irdata_o, 32'd0);
      repeat (3) cyc();
      @(negedge clk);
      checkVal("t6_proto_sticky", proto_err_o, 32'd1);
      cyc(); rst = 1'b1;
      cyc(); rst = 1'b0; rvalidAuto = 1'b1; @(negedge clk);
      checkVal("t6_proto_cleared", proto_err_o, 32'd0);

      checkVal("sb_leftover", expQ.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
